// File: rtl/sm_add_pipe.sv
// Two-stage sign-magnitude adder with valid/ready handshakes on both sides.
// Stage 1 holds the 34-bit two's-complement sum, stage 2 the sign-magnitude result.
module sm_add_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      A_out,
  input  logic [31:0]      B_out,
  input  logic [1:0]       c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32:0]      R,
  output logic             ovf,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] op_cnt
);

  logic        s1_valid;
  logic [33:0] s1_sum;
  logic        s2_load;
  logic        out_xfer;
  logic [33:0] ext_a, ext_b, op_a, op_b;
  logic        sum_neg;
  logic [32:0] mag;

  assign ext_a = {2'b00, A_out};
  assign ext_b = {2'b00, B_out};
  assign op_a  = c[1] ? (34'd0 - ext_a) : ext_a;
  assign op_b  = c[0] ? (34'd0 - ext_b) : ext_b;

  // Stage 2 frees up whenever it is empty or being drained this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign out_xfer = out_valid && out_ready;

  // The sum spans +/-(2^33-2), so the low 33 bits negate cleanly.
  assign sum_neg = s1_sum[33];
  assign mag     = sum_neg ? (33'd0 - s1_sum[32:0]) : s1_sum[32:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sum     <= '0;
      out_valid  <= 1'b0;
      R          <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
      op_cnt     <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_sum <= op_a + op_b;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          R   <= {sum_neg & (mag != 33'd0), mag[31:0]};
          ovf <= mag[32];
        end
      end
      if (out_xfer) op_cnt <= op_cnt + CNT_W'(1);
      // A delivered overflow outranks a simultaneous clear.
      if (out_xfer && ovf)  ovf_sticky <= 1'b1;
      else if (ovf_clr)     ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm_add_pipe.sv
// Scoreboard bench for sm_add_pipe: expected results are queued on input
// transfer and compared on output transfer; handshakes are observed at negedge.
`timescale 1ns/1ps
module tb_sm_add_pipe;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      A_out = '0;
  logic [31:0]      B_out = '0;
  logic [1:0]       c = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [32:0]      R;
  logic             ovf;
  logic             ovf_sticky;
  logic             ovf_clr = 1'b0;
  logic [CNT_W-1:0] op_cnt;

  int checks = 0;
  int errors = 0;

  logic [33:0]      sb[$];
  int               acc_cnt = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  logic             sticky_model = 1'b0;
  logic             hold_prev = 1'b0;
  logic [32:0]      r_prev = '0;
  logic             ovf_prev = 1'b0;
  int               total_xfer = 0;

  sm_add_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_out(A_out), .B_out(B_out), .c(c), .out_valid(out_valid),
    .out_ready(out_ready), .R(R), .ovf(ovf), .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns {ovf, R} computed with plain signed integer arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] cc);
    longint va, vb, s, m;
    logic [32:0] r;
    logic ov;
    va = longint'({32'd0, a});
    vb = longint'({32'd0, b});
    if (cc[1]) va = -va;
    if (cc[0]) vb = -vb;
    s  = va + vb;
    m  = (s < 0) ? -s : s;
    r[31:0] = m[31:0];
    r[32]   = (s < 0) && (m != 0);
    ov      = (m > 64'h0000_0000_FFFF_FFFF);
    return {ov, r};
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    if (rst) begin
      sb.delete();
      cnt_model    = '0;
      sticky_model = 1'b0;
      hold_prev    = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_R", 64'(R), 64'(r_prev));
        chk("hold_ovf", 64'(ovf), 64'(ovf_prev));
      end
      chk("op_cnt", 64'(op_cnt), 64'(cnt_model));
      chk("ovf_sticky", 64'(ovf_sticky), 64'(sticky_model));
      if (in_valid && in_ready) begin
        sb.push_back(model(A_out, B_out, c));
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("R", 64'(R), 64'(e[32:0]));
          chk("ovf", 64'(ovf), 64'(e[33]));
        end
        cnt_model = cnt_model + CNT_W'(1);
        total_xfer++;
        if (ovf) sticky_model = 1'b1;
        else if (ovf_clr) sticky_model = 1'b0;
      end else if (ovf_clr) begin
        sticky_model = 1'b0;
      end
      hold_prev = out_valid && !out_ready;
      r_prev    = R;
      ovf_prev  = ovf;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cc);
    int n;
    in_valid = 1'b1;
    A_out = a;
    B_out = b;
    c = cc;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (n == 100) chk("send_timeout", 64'd0, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    if (n == 100) chk("drain_timeout", 64'd0, 64'd1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] base;
    int base_acc;
    int n;

    // reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_R", 64'(R), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_op_cnt", 64'(op_cnt), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // basic add with latency check
    out_ready = 1'b1;
    send(32'd5, 32'd3, 2'b00);
    chk("lat_early", 64'(out_valid), 64'd0);
    step();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_R", 64'(R), {31'd0, 33'd8});
    drain();
    chk("cnt_one", 64'(op_cnt), 64'd1);

    // sign handling and zero results
    send(32'd3, 32'd5, 2'b01);
    send(32'd7, 32'd7, 2'b01);
    send(32'd0, 32'd0, 2'b11);
    send(32'd9, 32'd4, 2'b10);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
    drain();

    // overflow, sticky and clear
    send(32'hFFFF_FFFF, 32'd1, 2'b11);
    drain();
    chk("sticky_set", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("sticky_clr", 64'(ovf_sticky), 64'd0);

    // set wins over a simultaneous clear
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
    for (n = 0; n < 10 && !out_valid; n++) step();
    chk("ovf_pending", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("set_wins", 64'(ovf_sticky), 64'd1);
    drain();

    // backpressure: two accepted, third stalls, results in order
    base = op_cnt;
    base_acc = acc_cnt;
    out_ready = 1'b0;
    fork
      begin
        send(32'd100, 32'd1, 2'b00);
        send(32'd200, 32'd2, 2'b01);
        send(32'd300, 32'd3, 2'b10);
      end
      begin
        repeat (4) step();
        chk("bp_accepted", 64'(acc_cnt - base_acc), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_cnt", 64'(CNT_W'(op_cnt - base)), 64'd3);

    // reset with two results in flight
    out_ready = 1'b0;
    send(32'd11, 32'd22, 2'b00);
    send(32'd33, 32'd44, 2'b00);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(op_cnt), 64'd0);
    chk("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("mid_rst_R", 64'(R), 64'd0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    total_xfer = 0;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("no_stale", 64'(out_valid), 64'd0);
      step();
    end

    // random stream with random output backpressure
    fork
      begin
        for (int i = 0; i < 40; i++)
          send($urandom, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
               2'($urandom_range(0, 3)));
      end
      begin
        repeat (120) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // counter wrap: top up to exactly 2^CNT_W deliveries since reset
    while (total_xfer < (1 << CNT_W)) begin
      send($urandom, $urandom, 2'($urandom_range(0, 3)));
      drain();
    end
    chk("cnt_total", 64'(total_xfer), 64'(1 << CNT_W));
    chk("cnt_wrap", 64'(op_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
